alu_mc: RTL and testbench

Parametrised multi-cycle ALU with registered outputs and valid/ready handshakes on both sides. It is the next generation of the team's 6-bit combinational ALU. It keeps the 3-bit op select and 2-bit flag output, and adds a configurable width, iterative unsigned multiply and divide, and flow control. It sits between an operand source (sequencer or bench driver) and a result sink that may apply backpressure.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mc_iter.sv | 87 ++++++++
 rtl/alu_mc.sv | 122 ++++++++++++
 tb/tb_alu_mc.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and flag positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int F_ZERO = 0;
  localparam int F_AUX  = 1;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath shared by unsigned shift-add multiply (mode=0) and
// restoring divide (mode=1); one bit per cycle, WIDTH cycles after start.
module alu_mc_iter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] value,
  output logic             aux
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             active_q, active_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH:0]   rem_q, rem_d, rem_step;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] rem_sh, rem_diff;

  // MUL keeps the product in acc; DIV shifts the dividend out of acc's low half
  // into the remainder while quotient bits shift in behind it.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {rem_q, acc_q[WIDTH-1]};
    rem_diff = rem_sh - {2'b00, opnd_q};
    if (mode_q) begin
      acc_step = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~rem_diff[WIDTH+1]};
      rem_step = rem_diff[WIDTH+1] ? rem_sh[WIDTH:0] : rem_diff[WIDTH:0];
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      rem_step = rem_q;
    end
  end

  assign done  = active_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign value = acc_step[WIDTH-1:0];
  assign aux   = mode_q ? (opnd_q == '0) : (|acc_step[2*WIDTH-1:WIDTH]);

  always_comb begin
    active_d = active_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    if (start) begin
      active_d = 1'b1;
      mode_d   = mode;
      cnt_d    = '0;
      rem_d    = '0;
      opnd_d   = mode ? b : a;
      acc_d    = {{WIDTH{1'b0}}, (mode ? a : b)};
    end else if (active_q) begin
      acc_d = acc_step;
      rem_d = rem_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (done) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
    end else begin
      active_q <= active_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ops and registered result/flags.
module alu_mc #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       f
);

  import alu_pkg::*;

  state_e           state_q, state_d;
  logic             cool_q, cool_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       f_q, f_d;
  logic             accept, is_iter_op;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] comb_res;
  logic             comb_aux;
  logic             iter_done, iter_aux;
  logic [WIDTH-1:0] iter_value;

  assign is_iter_op = (s == OP_MUL) || (s == OP_DIV);
  assign accept     = in_valid & in_ready;
  assign add_w      = {1'b0, a} + {1'b0, b};
  assign sub_w      = {1'b0, a} - {1'b0, b};

  always_comb begin
    comb_res = '0;
    comb_aux = 1'b0;
    case (s)
      OP_ADD: begin comb_res = add_w[WIDTH-1:0]; comb_aux = add_w[WIDTH]; end
      OP_SUB: begin comb_res = sub_w[WIDTH-1:0]; comb_aux = sub_w[WIDTH]; end
      OP_AND: comb_res = a & b;
      OP_OR:  comb_res = a | b;
      OP_XOR: comb_res = a ^ b;
      OP_NOT: comb_res = ~a;
      default: ;
    endcase
  end

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & is_iter_op),
    .mode  (s[0]),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .value (iter_value),
    .aux   (iter_aux)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_iter_op ? ST_BUSY : ST_DONE;
      ST_BUSY: if (iter_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // cool_q blocks accepts for the single IDLE cycle right after a handshake.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !cool_q;
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    result_d = result_q;
    f_d      = f_q;
    cool_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && !is_iter_op) begin
          result_d      = comb_res;
          f_d[F_ZERO]   = (comb_res == '0);
          f_d[F_AUX]    = comb_aux;
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          result_d      = iter_value;
          f_d[F_ZERO]   = (iter_value == '0);
          f_d[F_AUX]    = iter_aux;
        end
      end
      ST_DONE: cool_d = out_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cool_q   <= 1'b0;
      result_q <= '0;
      f_q      <= 2'b00;
    end else begin
      cool_q   <= cool_d;
      result_q <= result_d;
      f_q      <= f_d;
    end
  end

  assign result = result_q;
  assign f      = f_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=6): directed plan cases, backpressure,
// mid-transaction reset and randomized ops against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 6;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   s;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [1:0]   f;

  int errors = 0;
  int checks = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .f         (f)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Returns {f[1], f[0], result} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_alu(input int op, input int av, input int bv);
    int r;
    int t;
    bit aux;
    logic [W+1:0] out;
    r = 0;
    aux = 1'b0;
    case (op)
      0: begin t = av + bv; r = t % M; aux = (t >= M); end
      1: begin r = (av - bv + M) % M; aux = (av < bv); end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = (M - 1) - av;
      6: begin t = av * bv; r = t % M; aux = (t >= M); end
      default: begin
        if (bv == 0) begin r = M - 1; aux = 1'b1; end
        else r = av / bv;
      end
    endcase
    out[W-1:0] = r[W-1:0];
    out[W]     = (r == 0);
    out[W+1]   = aux;
    return out;
  endfunction

  task automatic apply_stimulus(input int op, input int av, input int bv, input int hold, input string tag);
    logic [W+1:0] exp;
    int k;
    int lat_exp;
    exp     = ref_alu(op, av, bv);
    lat_exp = (op >= 6) ? W + 1 : 1;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    check_output({tag, " in_ready"}, in_ready, 1);
    s = op[2:0]; a = av[W-1:0]; b = bv[W-1:0];
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    s = 3'($urandom); a = W'($urandom); b = W'($urandom);
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    check_output({tag, " latency"}, k + 1, lat_exp);
    check_output({tag, " result"}, result, exp[W-1:0]);
    check_output({tag, " f"}, f, exp[W+1:W]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output({tag, " held valid"}, out_valid, 1);
      check_output({tag, " held result"}, result, exp[W-1:0]);
      check_output({tag, " held f"}, f, exp[W+1:W]);
      check_output({tag, " held in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_output({tag, " consumed"}, out_valid, 0);
    check_output({tag, " cooldown"}, in_ready, 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check_output({tag, " ready again"}, in_ready, 1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s = '0; a = '0; b = '0;
    @(posedge clk); #1;
    check_output("reset out_valid", out_valid, 0);
    check_output("reset in_ready", in_ready, 1);
    check_output("reset result", result, 0);
    check_output("reset f", f, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(0, 62, 3, 0, "add carry");
    apply_stimulus(0, 0, 0, 0, "add zero");
    apply_stimulus(1, 5, 5, 0, "sub equal");
    apply_stimulus(1, 3, 5, 0, "sub borrow");
    apply_stimulus(6, 7, 9, 0, "mul 7x9");
    apply_stimulus(6, 8, 8, 0, "mul ovf");
    apply_stimulus(7, 45, 7, 0, "div 45/7");
    apply_stimulus(7, 9, 0, 0, "div by zero");
    apply_stimulus(4, 21, 42, 4, "xor backpressure");
    apply_stimulus(5, 63, 0, 0, "not ones");
    apply_stimulus(6, 63, 63, 2, "mul max");

    // Reset during the third MUL iteration abandons the transaction.
    s = 3'd6; a = 6'd7; b = 6'd9; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midreset out_valid", out_valid, 0);
    check_output("midreset result", result, 0);
    check_output("midreset f", f, 0);
    check_output("midreset in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_output("no stale result", seen, 0);
    check_output("post reset in_ready", in_ready, 1);
    out_ready = 1'b0;
    apply_stimulus(7, 63, 2, 0, "post reset div");

    for (int i = 0; i < 30; i++) begin
      apply_stimulus($urandom_range(0, 7), $urandom_range(0, M - 1),
                     $urandom_range(0, M - 1), $urandom_range(0, 2), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
